// File: rtl/pwm_bargraph_decoder.sv
// Receive-side monitor for the 8-channel PWM bargraph: windowed duty measurement,
// brightest-channel tracking, sweep direction and a one-entry event buffer.
module pwm_bargraph_decoder #(
  parameter int unsigned WINDOW_BITS = 8,
  parameter int unsigned THRESH      = 128
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [7:0]             pwm_in_i,
  input  logic [2:0]             duty_sel_i,
  output logic [WINDOW_BITS:0]   duty_out_o,
  output logic                   frame_tick_o,
  output logic [2:0]             pos_o,
  output logic                   dir_o,
  output logic                   locked_o,
  output logic                   evt_valid_o,
  input  logic                   evt_ready_i,
  output logic [2:0]             evt_pos_o,
  output logic                   evt_dir_o,
  output logic                   overrun_o
);

  localparam int unsigned DW = WINDOW_BITS + 1;
  localparam logic [WINDOW_BITS-1:0] WinLast = '1;
  localparam logic [DW-1:0] ThreshL = DW'(THRESH);

  logic [WINDOW_BITS-1:0] win_q, win_d;
  logic [DW-1:0]          acc_q [8];
  logic [DW-1:0]          acc_d [8];
  logic [DW-1:0]          duty_q [8];
  logic [DW-1:0]          duty_d [8];
  logic                   frame_tick_q, frame_tick_d;
  logic [2:0]             pos_q, pos_d;
  logic                   dir_q, dir_d;
  logic                   locked_q, locked_d;
  logic                   seen_lock_q, seen_lock_d;
  logic                   evt_valid_q, evt_valid_d;
  logic [2:0]             evt_pos_q, evt_pos_d;
  logic                   evt_dir_q, evt_dir_d;
  logic                   overrun_q, overrun_d;

  logic [DW-1:0]          peak;
  logic [2:0]             peak_idx;
  logic                   gen_evt;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    peak     = '0;
    peak_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (duty_q[i] > peak) begin
        peak     = duty_q[i];
        peak_idx = 3'(i);
      end
    end
  end

  always_comb begin
    win_d        = win_q + 1'b1;
    frame_tick_d = (win_q == WinLast);
    for (int unsigned i = 0; i < 8; i++) begin
      acc_d[i]  = acc_q[i] + DW'(pwm_in_i[i]);
      duty_d[i] = duty_q[i];
      if (frame_tick_d) begin
        duty_d[i] = acc_d[i];
        acc_d[i]  = '0;
      end
    end

    pos_d       = pos_q;
    dir_d       = dir_q;
    locked_d    = locked_q;
    seen_lock_d = seen_lock_q;
    gen_evt     = 1'b0;
    if (frame_tick_q) begin
      if (peak >= ThreshL) begin
        locked_d = 1'b1;
        pos_d    = peak_idx;
        if (!seen_lock_q) begin
          dir_d       = 1'b0;
          gen_evt     = 1'b1;
          seen_lock_d = 1'b1;
        end else if (peak_idx > pos_q) begin
          dir_d   = 1'b0;
          gen_evt = 1'b1;
        end else if (peak_idx < pos_q) begin
          dir_d   = 1'b1;
          gen_evt = 1'b1;
        end
      end else begin
        locked_d = 1'b0;
      end
    end

    evt_valid_d = evt_valid_q;
    evt_pos_d   = evt_pos_q;
    evt_dir_d   = evt_dir_q;
    overrun_d   = overrun_q;
    // A new event always wins over an accept; only an unaccepted overwrite is an overrun.
    if (gen_evt) begin
      evt_valid_d = 1'b1;
      evt_pos_d   = pos_d;
      evt_dir_d   = dir_d;
      if (evt_valid_q && !evt_ready_i) overrun_d = 1'b1;
    end else if (evt_valid_q && evt_ready_i) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      win_q <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        acc_q[i]  <= '0;
        duty_q[i] <= '0;
      end
      frame_tick_q <= 1'b0;
      pos_q        <= '0;
      dir_q        <= 1'b0;
      locked_q     <= 1'b0;
      seen_lock_q  <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_pos_q    <= '0;
      evt_dir_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      win_q <= win_d;
      for (int unsigned i = 0; i < 8; i++) begin
        acc_q[i]  <= acc_d[i];
        duty_q[i] <= duty_d[i];
      end
      frame_tick_q <= frame_tick_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      locked_q     <= locked_d;
      seen_lock_q  <= seen_lock_d;
      evt_valid_q  <= evt_valid_d;
      evt_pos_q    <= evt_pos_d;
      evt_dir_q    <= evt_dir_d;
      overrun_q    <= overrun_d;
    end
  end

  assign duty_out_o   = duty_q[duty_sel_i];
  assign frame_tick_o = frame_tick_q;
  assign pos_o        = pos_q;
  assign dir_o        = dir_q;
  assign locked_o     = locked_q;
  assign evt_valid_o  = evt_valid_q;
  assign evt_pos_o    = evt_pos_q;
  assign evt_dir_o    = evt_dir_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_pwm_bargraph_decoder.sv
// Directed bench for pwm_bargraph_decoder; PWM levels are generated from a
// counter aligned to reset release, so cycle numbers match the window timing.
module tb_pwm_bargraph_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pwm_in = '0;
  logic [2:0] duty_sel = '0;
  logic [8:0] duty_out;
  logic       frame_tick, dir, locked, evt_valid, evt_ready = 1'b0, evt_dir, overrun;
  logic [2:0] pos, evt_pos;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lvl [8];

  always #10 clk = ~clk;

  pwm_bargraph_decoder #(.WINDOW_BITS(8), .THRESH(128)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pwm_in_i(pwm_in), .duty_sel_i(duty_sel),
    .duty_out_o(duty_out), .frame_tick_o(frame_tick), .pos_o(pos), .dir_o(dir),
    .locked_o(locked), .evt_valid_o(evt_valid), .evt_ready_i(evt_ready),
    .evt_pos_o(evt_pos), .evt_dir_o(evt_dir), .overrun_o(overrun)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic drive();
    for (int i = 0; i < 8; i++) pwm_in[i] = ((cyc % 256) < lvl[i]);
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    drive();
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic set_peak(input int ch, input int val);
    for (int i = 0; i < 8; i++) lvl[i] = 0;
    lvl[ch] = val;
    drive();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    cyc = 0;
    drive();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) lvl[i] = 0;
    evt_ready = 1'b0;
    do_reset(3);
    checks++; if ({frame_tick, pos, dir, locked, evt_valid, evt_pos, evt_dir, overrun} !== 12'd0) begin errors++; $display("FAIL reset_outputs: got %b want 0", {frame_tick, pos, dir, locked, evt_valid, evt_pos, evt_dir, overrun}); end
    checks++; if (duty_out !== 9'd0) begin errors++; $display("FAIL reset_duty: got %0d want 0", duty_out); end
    while (cyc < 300) begin
      checks++; if (frame_tick !== (cyc == 256)) begin errors++; $display("FAIL idle_tick c%0d: got %b want %b", cyc, frame_tick, cyc == 256); end
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL idle_evt c%0d: got %b want 0", cyc, evt_valid); end
      if (cyc == 257) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL idle_locked: got %b want 0", locked); end
        for (int s = 0; s < 8; s++) begin
          duty_sel = 3'(s); #1;
          checks++; if (duty_out !== 9'd0) begin errors++; $display("FAIL idle_duty sel%0d: got %0d want 0", s, duty_out); end
        end
      end
      step();
    end
  endtask

  task automatic test_static();
    for (int i = 0; i < 8; i++) lvl[i] = 0;
    lvl[2] = 100; lvl[3] = 255; lvl[4] = 100;
    evt_ready = 1'b0;
    do_reset(3);
    run_to(256);
    duty_sel = 3'd3; #1;
    checks++; if (duty_out !== 9'd255) begin errors++; $display("FAIL static_duty3: got %0d want 255", duty_out); end
    duty_sel = 3'd2; #1;
    checks++; if (duty_out !== 9'd100) begin errors++; $display("FAIL static_duty2: got %0d want 100", duty_out); end
    duty_sel = 3'd0; #1;
    checks++; if (duty_out !== 9'd0) begin errors++; $display("FAIL static_duty0: got %0d want 0", duty_out); end
    lvl[3] = 256; drive();
    step();
    checks++; if ({pos, locked, dir, evt_valid, evt_pos} !== {3'd3, 1'b1, 1'b0, 1'b1, 3'd3}) begin errors++; $display("FAIL static_eval: got pos=%0d lk=%b dir=%b v=%b ep=%0d want 3 1 0 1 3", pos, locked, dir, evt_valid, evt_pos); end
    run_to(512);
    duty_sel = 3'd3; #1;
    checks++; if (duty_out !== 9'd256) begin errors++; $display("FAIL static_full: got %0d want 256", duty_out); end
    step();
    checks++; if ({pos, evt_valid, evt_pos, overrun} !== {3'd3, 1'b1, 3'd3, 1'b0}) begin errors++; $display("FAIL static_hold: got pos=%0d v=%b ep=%0d ov=%b want 3 1 3 0", pos, evt_valid, evt_pos, overrun); end
  endtask

  task automatic test_sweep();
    set_peak(3, 200);
    evt_ready = 1'b1;
    do_reset(3);
    run_to(256); set_peak(4, 200);
    run_to(257);
    checks++; if ({evt_valid, evt_pos} !== {1'b1, 3'd3}) begin errors++; $display("FAIL sweep_first: got v=%b ep=%0d want 1 3", evt_valid, evt_pos); end
    step();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL sweep_first_clr: got %b want 0", evt_valid); end
    run_to(512); set_peak(2, 200);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL sweep_pre4: got %b want 0", evt_valid); end
    step();
    checks++; if ({evt_valid, evt_pos, evt_dir, dir} !== {1'b1, 3'd4, 1'b0, 1'b0}) begin errors++; $display("FAIL sweep_up: got v=%b ep=%0d ed=%b dir=%b want 1 4 0 0", evt_valid, evt_pos, evt_dir, dir); end
    step();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL sweep_up_pulse: got %b want 0", evt_valid); end
    run_to(769);
    checks++; if ({evt_valid, evt_pos, evt_dir, dir} !== {1'b1, 3'd2, 1'b1, 1'b1}) begin errors++; $display("FAIL sweep_down: got v=%b ep=%0d ed=%b dir=%b want 1 2 1 1", evt_valid, evt_pos, evt_dir, dir); end
    step();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL sweep_down_pulse: got %b want 0", evt_valid); end
    run_to(1025);
    checks++; if ({evt_valid, pos, dir, locked} !== {1'b0, 3'd2, 1'b1, 1'b1}) begin errors++; $display("FAIL sweep_same: got v=%b pos=%0d dir=%b lk=%b want 0 2 1 1", evt_valid, pos, dir, locked); end
  endtask

  task automatic test_tie();
    for (int i = 0; i < 8; i++) lvl[i] = 0;
    lvl[1] = 200; lvl[5] = 200;
    evt_ready = 1'b1;
    do_reset(3);
    run_to(256);
    duty_sel = 3'd5; #1;
    checks++; if (duty_out !== 9'd200) begin errors++; $display("FAIL tie_duty5: got %0d want 200", duty_out); end
    step();
    checks++; if ({pos, locked} !== {3'd1, 1'b1}) begin errors++; $display("FAIL tie_pos: got pos=%0d lk=%b want 1 1", pos, locked); end
  endtask

  task automatic test_backpressure();
    set_peak(3, 200);
    evt_ready = 1'b0;
    do_reset(3);
    run_to(256); set_peak(4, 200);
    run_to(257);
    checks++; if ({evt_valid, evt_pos, overrun} !== {1'b1, 3'd3, 1'b0}) begin errors++; $display("FAIL bp_first: got v=%b ep=%0d ov=%b want 1 3 0", evt_valid, evt_pos, overrun); end
    run_to(512); set_peak(5, 200);
    run_to(513);
    checks++; if ({evt_valid, evt_pos, overrun} !== {1'b1, 3'd4, 1'b1}) begin errors++; $display("FAIL bp_over1: got v=%b ep=%0d ov=%b want 1 4 1", evt_valid, evt_pos, overrun); end
    run_to(769);
    checks++; if ({evt_valid, evt_pos, evt_dir, overrun} !== {1'b1, 3'd5, 1'b0, 1'b1}) begin errors++; $display("FAIL bp_over2: got v=%b ep=%0d ed=%b ov=%b want 1 5 0 1", evt_valid, evt_pos, evt_dir, overrun); end
    run_to(800);
    checks++; if ({evt_valid, evt_pos, overrun} !== {1'b1, 3'd5, 1'b1}) begin errors++; $display("FAIL bp_hold: got v=%b ep=%0d ov=%b want 1 5 1", evt_valid, evt_pos, overrun); end
    evt_ready = 1'b1;
    step();
    checks++; if ({evt_valid, overrun} !== {1'b0, 1'b1}) begin errors++; $display("FAIL bp_drain: got v=%b ov=%b want 0 1", evt_valid, overrun); end
  endtask

  task automatic test_back_to_back();
    set_peak(3, 200);
    evt_ready = 1'b0;
    do_reset(3);
    run_to(256); set_peak(4, 200);
    run_to(512);
    evt_ready = 1'b1;
    checks++; if ({evt_valid, evt_pos} !== {1'b1, 3'd3}) begin errors++; $display("FAIL b2b_pending: got v=%b ep=%0d want 1 3", evt_valid, evt_pos); end
    step();
    checks++; if ({evt_valid, evt_pos, overrun} !== {1'b1, 3'd4, 1'b0}) begin errors++; $display("FAIL b2b_load: got v=%b ep=%0d ov=%b want 1 4 0", evt_valid, evt_pos, overrun); end
    step();
    checks++; if ({evt_valid, overrun} !== {1'b0, 1'b0}) begin errors++; $display("FAIL b2b_accept: got v=%b ov=%b want 0 0", evt_valid, overrun); end
  endtask

  task automatic test_threshold_reset();
    set_peak(3, 200);
    evt_ready = 1'b1;
    do_reset(3);
    run_to(256); set_peak(5, 100);
    run_to(257);
    checks++; if ({locked, pos} !== {1'b1, 3'd3}) begin errors++; $display("FAIL thr_lock: got lk=%b pos=%0d want 1 3", locked, pos); end
    run_to(512); set_peak(3, 200);
    run_to(513);
    checks++; if ({locked, pos, evt_valid} !== {1'b0, 3'd3, 1'b0}) begin errors++; $display("FAIL thr_low: got lk=%b pos=%0d v=%b want 0 3 0", locked, pos, evt_valid); end
    run_to(612);
    do_reset(1);
    duty_sel = 3'd3; #1;
    checks++; if ({duty_out, frame_tick, locked} !== {9'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL mid_reset_clr: got d=%0d ft=%b lk=%b want 0 0 0", duty_out, frame_tick, locked); end
    while (cyc < 257) begin
      step();
      checks++; if (frame_tick !== (cyc == 256)) begin errors++; $display("FAIL mid_reset_tick c%0d: got %b want %b", cyc, frame_tick, cyc == 256); end
      if (cyc == 256) begin
        checks++; if (duty_out !== 9'd200) begin errors++; $display("FAIL mid_reset_duty: got %0d want 200", duty_out); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) lvl[i] = 0;
    test_reset();
    test_static();
    test_sweep();
    test_tie();
    test_backpressure();
    test_back_to_back();
    test_threshold_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
